scroll_matrix_scan: RTL and testbench
=====================================

# scroll_matrix_scan

Parametrised row-scan and scroll-index generator for the LED dot-matrix display path. Drives a one-hot row enable, the matching row number, and a message column address `(idx + row) mod MSG_LEN` that the pattern ROM consumes. Adds the following over the fixed 8-row/81-column scanner:

- direction control
- pause
- a frame-rate prescaler so scrolling only advances on frame boundaries
- modular address wrap
- row/address alignment in the same cycle

## Interface

Parameters:

- `ROWS`, 8: rows scanned per frame; 2..MSG_LEN.
- `MSG_LEN`, 81: message length in columns; ≥ ROWS.
- `IDX_W`, 7: index/address width; 2^IDX_W ≥ MSG_LEN.
- `FRAMES_PER_STEP`, 1: complete frames per scroll step; ≥ 1.

Ports:

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: scan tick enable; when low, all state holds.
- `dir` in 1: 0 = down (idx decrements), 1 = up (idx increments).
- `pause` in 1: freezes idx; row scan continues.
- `row` out ROWS: one-hot row enable, `1 << row_cnt`.
- `row_cnt` out $clog2(ROWS): current row number.
- `addr` out IDX_W: `(idx + row_cnt) mod MSG_LEN`, aligned with `row`.
- `idx` out IDX_W: current scroll offset.
- `frame_start` out 1: one-cycle pulse while outputs present row 0 after a wrap.
- `step` out 1: one-cycle pulse on the cycle idx presents a new value.

## Operation

- All outputs are registered and update only on `en`-qualified cycles; on `en=0`, every register holds and both pulses are 0.

**Row scan**
- `row_cnt` advances 0→1→…→ROWS-1→0.
- `row` is the one-hot decode of the next `row_cnt`, registered in the same cycle.

**Frame counter**
- `fcnt` runs 0..FRAMES_PER_STEP-1.
- Increments when `row_cnt` wraps ROWS-1→0.

**Scroll step**
- Occurs on the row wrap when `fcnt == FRAMES_PER_STEP-1` and `pause=0`.
- `dir=0`: idx-1, wrapping 0→MSG_LEN-1.
- `dir=1`: idx+1, wrapping MSG_LEN-1→0.
- `dir` is sampled only at the step; a change mid-frame takes effect at the next step.
- With `pause=1` at a step point, `fcnt` still wraps to 0, idx holds, and `step` stays 0.

**Address**
- Computed from the next idx and next `row_cnt`.
- Sum is IDX_W+1 bits wide; subtract MSG_LEN once if sum ≥ MSG_LEN. A single subtract is sufficient because idx < MSG_LEN and row_cnt < ROWS ≤ MSG_LEN.

**Reset values**
- `row_cnt`=0, `row`='b1, `fcnt`=0.
- `idx`=MSG_LEN-1, `addr`=MSG_LEN-1.
- `frame_start`=0, `step`=0.

**Simultaneous events**
- `rst` has priority over `en`.
- Reset mid-frame restarts at row 0 with idx=MSG_LEN-1, regardless of `dir`/`pause`.

## Timing

- Latency is one cycle from an `en`-qualified edge to the new `row`/`row_cnt`/`addr`/`idx`.
- `row`, `row_cnt` and `addr` always describe the same row in the same cycle; there is no one-cycle address lag.
- `frame_start` and `step` assert in the same cycle as `row_cnt` = 0. `step` implies `frame_start`.
- With `en` tied high, the frame period is ROWS cycles and the step period is ROWS·FRAMES_PER_STEP cycles.
- The first frame after reset gives no `frame_start`; the first pulse occurs ROWS enabled cycles after reset release.

## Structure

- Shared package `led_matrix_pkg` holds:
  - `DIR_DOWN`=1'b0, `DIR_UP`=1'b1
  - default `ROWS`/`MSG_LEN` constants
  - the modular-add function used for `addr`
- Sub-module `scroll_idx`:
  - ports: clk, rst, advance, dir → idx
  - up/down counter with wrap, parametrised by MSG_LEN/IDX_W
- Row scan, frame counter and address logic stay in the top module.

## Test plan

- **Reset then free-run**, defaults, `en`=1, `dir`=0:
  - cycle 0: row=8'h01, addr=80
  - cycle 1: row=8'h02, addr=0
  - cycle 8: row=8'h01, idx=79, addr=79, frame_start=step=1
- **Wrap down**: run until idx=0, then one more frame → idx=80, step=1. During the idx=0 frame, addr sequence is 0..7.
- **Up direction with wrap**, `dir`=1, from idx=80 → next step idx=0. In the idx=80 frame, addr sequence is 80,0,1,…,6.
- **Prescaler and pause**, FRAMES_PER_STEP=3:
  - steps occur every 24 cycles
  - `pause` asserted over one step point → idx unchanged, frame_start=1, step=0, next step 24 cycles later
- **Enable gating**: `en`=0 for 5 cycles mid-frame (row_cnt=3) → all outputs frozen, no pulses; resumes at row_cnt=4.
- **Mid-operation reset and odd parameters**:
  - `rst` at row_cnt=5, idx=40 → next cycle row_cnt=0, idx=80, pulses 0
  - repeat with ROWS=5, MSG_LEN=7 → addr always < 7

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared constants and index arithmetic for the LED dot-matrix scan path.
package led_matrix_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int DEF_ROWS    = 8;
  localparam int DEF_MSG_LEN = 81;
  localparam int DEF_IDX_W   = 7;

  // Operand width of the helpers; callers zero-extend into it and truncate back.
  localparam int OP_W = 16;

  // (a + b) mod m for a < m and b <= m; one subtract is enough in that range.
  function automatic logic [OP_W-1:0] mod_add(input logic [OP_W-1:0] a,
                                              input logic [OP_W-1:0] b,
                                              input logic [OP_W-1:0] m);
    logic [OP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) begin
      sum = sum - {1'b0, m};
    end else begin
      sum = sum;
    end
    return sum[OP_W-1:0];
  endfunction

  // One scroll step in the requested direction, wrapping within 0..m-1.
  function automatic logic [OP_W-1:0] idx_step(input logic [OP_W-1:0] idx,
                                               input logic            dir,
                                               input logic [OP_W-1:0] m);
    logic [OP_W-1:0] nxt;
    if (dir == DIR_UP) begin
      nxt = (idx == m - 16'd1) ? 16'd0 : idx + 16'd1;
    end else begin
      nxt = (idx == 16'd0) ? m - 16'd1 : idx - 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/scroll_matrix_scan_if.sv
// Control and display-side signals of the row-scan / scroll-index generator.
interface scroll_matrix_scan_if #(
  parameter int ROWS  = led_matrix_pkg::DEF_ROWS,
  parameter int IDX_W = led_matrix_pkg::DEF_IDX_W
);
  localparam int RC_W = $clog2(ROWS);

  logic              en;
  logic              dir;
  logic              pause;
  logic [ROWS-1:0]   row;
  logic [RC_W-1:0]   row_cnt;
  logic [IDX_W-1:0]  addr;
  logic [IDX_W-1:0]  idx;
  logic              frame_start;
  logic              step;

  modport master (output en, dir, pause,
                  input  row, row_cnt, addr, idx, frame_start, step);
  modport slave  (input  en, dir, pause,
                  output row, row_cnt, addr, idx, frame_start, step);
endinterface

// File: rtl/scroll_idx.sv
// Scroll offset register: up/down counter wrapping within 0..MSG_LEN-1.
module scroll_idx
  import led_matrix_pkg::*;
#(
  parameter int MSG_LEN = DEF_MSG_LEN,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             dir,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] idx_r;

  // Offset register; moves one column only when the top qualifies a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= IDX_W'(MSG_LEN - 1);
    end else if (advance) begin
      idx_r <= IDX_W'(idx_step(OP_W'(idx_r), dir, OP_W'(MSG_LEN)));
    end else begin
      idx_r <= idx_r;
    end
  end

  assign idx = idx_r;

endmodule

// File: rtl/scroll_matrix_scan.sv
// Row scanner with frame prescaler and scrolling column address for the LED matrix.
module scroll_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS            = DEF_ROWS,
  parameter int MSG_LEN         = DEF_MSG_LEN,
  parameter int IDX_W           = DEF_IDX_W,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  scroll_matrix_scan_if.slave  bus
);

  localparam int RC_W = $clog2(ROWS);
  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [RC_W-1:0]  row_cnt_r;
  logic [ROWS-1:0]  row_r;
  logic [FC_W-1:0]  fcnt_r;
  logic [IDX_W-1:0] addr_r;
  logic             frame_start_r;
  logic             step_r;

  logic             row_wrap_s;
  logic             fcnt_last_s;
  logic             advance_s;
  logic [RC_W-1:0]  row_cnt_nxt_s;
  logic [ROWS-1:0]  row_nxt_s;
  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [IDX_W-1:0] addr_nxt_s;

  scroll_idx #(
    .MSG_LEN (MSG_LEN),
    .IDX_W   (IDX_W)
  ) u_scroll_idx (
    .clk     (clk),
    .rst     (rst),
    .advance (advance_s),
    .dir     (bus.dir),
    .idx     (idx_s)
  );

  // Next-state decode; addr is built from the next idx and row so it lands aligned with row.
  always_comb begin
    row_wrap_s  = (row_cnt_r == RC_W'(ROWS - 1));
    fcnt_last_s = (fcnt_r == FC_W'(FRAMES_PER_STEP - 1));
    if (row_wrap_s) begin
      row_cnt_nxt_s = {RC_W{1'b0}};
    end else begin
      row_cnt_nxt_s = row_cnt_r + RC_W'(1);
    end
    advance_s = bus.en & row_wrap_s & fcnt_last_s & ~bus.pause;
    if (advance_s) begin
      idx_nxt_s = IDX_W'(idx_step(OP_W'(idx_s), bus.dir, OP_W'(MSG_LEN)));
    end else begin
      idx_nxt_s = idx_s;
    end
    addr_nxt_s = IDX_W'(mod_add(OP_W'(idx_nxt_s), OP_W'(row_cnt_nxt_s), OP_W'(MSG_LEN)));
    row_nxt_s  = {{(ROWS-1){1'b0}}, 1'b1} << row_cnt_nxt_s;
  end

  // Scan state and registered outputs; pulses drop whenever the tick is absent.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_r     <= {RC_W{1'b0}};
      row_r         <= {{(ROWS-1){1'b0}}, 1'b1};
      fcnt_r        <= {FC_W{1'b0}};
      addr_r        <= IDX_W'(MSG_LEN - 1);
      frame_start_r <= 1'b0;
      step_r        <= 1'b0;
    end else if (bus.en) begin
      row_cnt_r <= row_cnt_nxt_s;
      row_r     <= row_nxt_s;
      if (row_wrap_s) begin
        fcnt_r <= fcnt_last_s ? {FC_W{1'b0}} : fcnt_r + FC_W'(1);
      end else begin
        fcnt_r <= fcnt_r;
      end
      addr_r        <= addr_nxt_s;
      frame_start_r <= row_wrap_s;
      step_r        <= advance_s;
    end else begin
      row_cnt_r     <= row_cnt_r;
      row_r         <= row_r;
      fcnt_r        <= fcnt_r;
      addr_r        <= addr_r;
      frame_start_r <= 1'b0;
      step_r        <= 1'b0;
    end
  end

  assign bus.row         = row_r;
  assign bus.row_cnt     = row_cnt_r;
  assign bus.addr        = addr_r;
  assign bus.idx         = idx_s;
  assign bus.frame_start = frame_start_r;
  assign bus.step        = step_r;

endmodule

// File: tb/tb_scroll_matrix_scan.sv
// Scoreboard bench for scroll_matrix_scan: default, prescaled and small-geometry instances.
module tb_scroll_matrix_scan;
  import led_matrix_pkg::*;

  typedef enum int {F_ROW, F_RC, F_ADDR, F_IDX, F_FS, F_STEP} field_t;
  typedef struct {
    int     inst;
    field_t fld;
    int     val;
    string  name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  scroll_matrix_scan_if #(.ROWS(8), .IDX_W(7)) if0 ();
  scroll_matrix_scan_if #(.ROWS(8), .IDX_W(7)) if1 ();
  scroll_matrix_scan_if #(.ROWS(5), .IDX_W(3)) if2 ();

  scroll_matrix_scan #(.ROWS(8), .MSG_LEN(81), .IDX_W(7), .FRAMES_PER_STEP(1))
    u0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  scroll_matrix_scan #(.ROWS(8), .MSG_LEN(81), .IDX_W(7), .FRAMES_PER_STEP(3))
    u1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  scroll_matrix_scan #(.ROWS(5), .MSG_LEN(7), .IDX_W(3), .FRAMES_PER_STEP(1))
    u2 (.clk(clk), .rst(rst2), .bus(if2.slave));

  function automatic int act(int inst, field_t f);
    int r;
    r = 0;
    case (inst)
      0: case (f)
           F_ROW: r = int'(if0.row);   F_RC: r = int'(if0.row_cnt); F_ADDR: r = int'(if0.addr);
           F_IDX: r = int'(if0.idx);   F_FS: r = int'(if0.frame_start); default: r = int'(if0.step);
         endcase
      1: case (f)
           F_ROW: r = int'(if1.row);   F_RC: r = int'(if1.row_cnt); F_ADDR: r = int'(if1.addr);
           F_IDX: r = int'(if1.idx);   F_FS: r = int'(if1.frame_start); default: r = int'(if1.step);
         endcase
      default: case (f)
           F_ROW: r = int'(if2.row);   F_RC: r = int'(if2.row_cnt); F_ADDR: r = int'(if2.addr);
           F_IDX: r = int'(if2.idx);   F_FS: r = int'(if2.frame_start); default: r = int'(if2.step);
         endcase
    endcase
    return r;
  endfunction

  task automatic expect_v(input int inst, input field_t f, input int v, input string nm);
    exp_t e;
    e.inst = inst; e.fld = f; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_all(input int inst, input int row, input int rc, input int addr,
                            input int idx, input int fs, input int st, input string nm);
    expect_v(inst, F_ROW, row, nm);
    expect_v(inst, F_RC, rc, nm);
    expect_v(inst, F_ADDR, addr, nm);
    expect_v(inst, F_IDX, idx, nm);
    expect_v(inst, F_FS, fs, nm);
    expect_v(inst, F_STEP, st, nm);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare everything queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = act(e.inst, e.fld);
      n_checks++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s inst%0d %s: got %0d expected %0d", e.name, e.inst, e.fld.name(), a, e.val);
      end
    end
  end

  initial begin
    int rc, id, p, st, steps;
    int up_addr[8];
    up_addr = '{80, 0, 1, 2, 3, 4, 5, 6};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.en = 1'b0; if0.dir = DIR_DOWN; if0.pause = 1'b0;
    if1.en = 1'b0; if1.dir = DIR_DOWN; if1.pause = 1'b0;
    if2.en = 1'b0; if2.dir = DIR_DOWN; if2.pause = 1'b0;
    cyc(); cyc();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    expect_all(0, 1, 0, 80, 80, 0, 0, "reset0");
    expect_all(1, 1, 0, 80, 80, 0, 0, "reset1");
    expect_all(2, 1, 0, 6, 6, 0, 0, "reset2");

    // Free run downwards through a full idx wrap
    if0.en = 1'b1;
    for (int n = 1; n <= 648; n++) begin
      cyc();
      rc = n % 8;
      id = ((80 - n / 8) % 81 + 81) % 81;
      p  = (n % 8 == 0) ? 1 : 0;
      expect_all(0, 1 << rc, rc, (id + rc) % 81, id, p, p, "free_down");
      if (n == 1) begin
        expect_v(0, F_ROW, 'h02, "c1_row");
        expect_v(0, F_ADDR, 0, "c1_addr");
      end
      if (n == 8) begin
        expect_v(0, F_ROW, 'h01, "c8_row");
        expect_v(0, F_IDX, 79, "c8_idx");
        expect_v(0, F_ADDR, 79, "c8_addr");
        expect_v(0, F_STEP, 1, "c8_step");
      end
      if (n >= 640 && n < 648) expect_v(0, F_ADDR, n - 640, "idx0_addr");
      if (n == 648) begin
        expect_v(0, F_IDX, 80, "wrap_down_idx");
        expect_v(0, F_STEP, 1, "wrap_down_step");
      end
    end

    // Up direction from idx=80
    if0.dir = DIR_UP;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      expect_all(0, 1 << k, k, up_addr[k], 80, 0, 0, "up_frame");
    end
    cyc();
    expect_all(0, 1, 0, 0, 0, 1, 1, "up_wrap");

    // dir wiggles mid-frame; only its value at the step point counts
    for (int k = 1; k <= 8; k++) begin
      cyc();
      rc = k % 8;
      id = (k == 8) ? 1 : 0;
      p  = (k == 8) ? 1 : 0;
      expect_all(0, 1 << rc, rc, id + rc, id, p, p, "dir_midframe");
      if (k == 3) if0.dir = DIR_DOWN;
      if (k == 5) if0.dir = DIR_UP;
    end

    // Enable gating at row_cnt=3
    for (int k = 1; k <= 3; k++) begin
      cyc();
      expect_all(0, 1 << k, k, 1 + k, 1, 0, 0, "pre_gate");
    end
    if0.en = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      cyc();
      expect_all(0, 'h08, 3, 4, 1, 0, 0, "gated");
    end
    if0.en = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      cyc();
      rc = k % 8;
      id = (k == 8) ? 2 : 1;
      p  = (k == 8) ? 1 : 0;
      expect_all(0, 1 << rc, rc, id + rc, id, p, p, "resume");
    end
    if0.en = 1'b0;
    cyc();
    expect_all(0, 1, 0, 2, 2, 0, 0, "pulse_clear");
    if0.en = 1'b1;

    // Climb to idx=40, stop at row_cnt=5, then reset with dir/pause set
    for (int m = 1; m <= 309; m++) begin
      cyc();
      rc = m % 8;
      id = 2 + m / 8;
      p  = (rc == 0) ? 1 : 0;
      expect_all(0, 1 << rc, rc, (id + rc) % 81, id, p, p, "climb");
    end
    expect_v(0, F_IDX, 40, "pre_rst_idx");
    expect_v(0, F_RC, 5, "pre_rst_rc");
    rst0 = 1'b1; if0.pause = 1'b1;
    cyc();
    expect_all(0, 1, 0, 80, 80, 0, 0, "mid_reset");
    rst0 = 1'b0; if0.pause = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      rc = n % 8;
      id = (n == 8) ? 0 : 80;
      p  = (n == 8) ? 1 : 0;
      expect_all(0, 1 << rc, rc, (id + rc) % 81, id, p, p, "post_reset");
    end

    // Prescaler of 3 frames with pause held over the step point at cycle 72
    if1.en = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      cyc();
      rc    = n % 8;
      steps = n / 24 - ((n >= 72) ? 1 : 0);
      id    = 80 - steps;
      p     = (rc == 0) ? 1 : 0;
      st    = (n % 24 == 0 && n != 72) ? 1 : 0;
      expect_all(1, 1 << rc, rc, (id + rc) % 81, id, p, st, "prescale");
      if (n == 24) expect_v(1, F_IDX, 79, "first_step_idx");
      if (n == 72) begin
        expect_v(1, F_IDX, 78, "pause_idx");
        expect_v(1, F_FS, 1, "pause_fs");
        expect_v(1, F_STEP, 0, "pause_step");
      end
      if (n == 96) expect_v(1, F_STEP, 1, "post_pause_step");
      if (n == 70) if1.pause = 1'b1;
      if (n == 72) if1.pause = 1'b0;
    end

    // ROWS=5, MSG_LEN=7 geometry
    if2.en = 1'b1;
    for (int n = 1; n <= 43; n++) begin
      cyc();
      rc = n % 5;
      id = ((6 - n / 5) % 7 + 7) % 7;
      p  = (rc == 0) ? 1 : 0;
      expect_all(2, 1 << rc, rc, (id + rc) % 7, id, p, p, "small_down");
    end
    rst2 = 1'b1; if2.dir = DIR_UP; if2.pause = 1'b1;
    cyc();
    expect_all(2, 1, 0, 6, 6, 0, 0, "small_reset");
    rst2 = 1'b0; if2.pause = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      rc = n % 5;
      id = (n >= 10) ? 1 : ((n >= 5) ? 0 : 6);
      p  = (rc == 0) ? 1 : 0;
      expect_all(2, 1 << rc, rc, (id + rc) % 7, id, p, p, "small_up");
    end

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
